nibble_piso: RTL

NIBBLE_PISO -- requirements
Module: nibble_piso

---
 rtl/nibble_piso_pkg.sv | 5 +
 rtl/nibble_piso.sv | 64 ++++++
 2 files changed

// File: rtl/nibble_piso_pkg.sv
// nibble_piso_pkg: shared nibble width and FSM state encoding for nibble_piso.
package nibble_piso_pkg;
  localparam int NIBBLE_W = 4;
  typedef enum logic {IDLE, SHIFT} state_t;
endpackage

// File: rtl/nibble_piso.sv
// nibble_piso: parallel-in serial-out nibble shifter with valid/ready on both sides.
// Define NIBBLE_PISO_MSB_FIRST_EN to emit the most-significant nibble first.
module nibble_piso
  import nibble_piso_pkg::*;
#(
  parameter int NIBBLES = 4
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic [NIBBLE_W*NIBBLES-1:0] in_data,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [NIBBLE_W-1:0]         out_data,
  output logic                        out_last,
  output logic                        busy
);
  localparam int W  = NIBBLE_W * NIBBLES;
  localparam int CW = $clog2(NIBBLES);

  state_t         r_state;
  logic [W-1:0]   r_shift;
  logic [CW-1:0]  r_cnt;
  logic           r_last;
  logic [W-1:0]   w_next;
  logic           w_out_hs;
  logic           w_load;

  assign out_valid = r_state == SHIFT;
  assign busy      = r_state == SHIFT;
  assign out_last  = r_last;
  assign w_out_hs  = out_valid & out_ready;
  // Accepting the final nibble frees the register, so a new word can load in the same cycle.
  assign in_ready  = (r_state == IDLE) | (w_out_hs & r_last);
  assign w_load    = in_valid & in_ready;

`ifdef NIBBLE_PISO_MSB_FIRST_EN
  assign out_data = r_shift[W-1 -: NIBBLE_W];
  assign w_next   = r_shift << NIBBLE_W;
`else
  assign out_data = r_shift[NIBBLE_W-1:0];
  assign w_next   = r_shift >> NIBBLE_W;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_shift <= '0;
      r_cnt   <= '0;
      r_last  <= 1'b0;
    end else if (w_load) begin
      r_state <= SHIFT;
      r_shift <= in_data;
      r_cnt   <= CW'(NIBBLES - 1);
      r_last  <= 1'b0;
    end else if (w_out_hs) begin
      r_state <= (r_cnt == '0) ? IDLE : SHIFT;
      r_shift <= w_next;
      r_cnt   <= (r_cnt == '0) ? '0 : r_cnt - CW'(1);
      r_last  <= r_cnt == CW'(1);
    end
  end
endmodule
